// File: rtl/config_cmd_parser.sv
// config_cmd_parser
//
// Purpose:
//   Sits between the UART receiver and the 32-entry configuration register
//   map. It frames incoming bytes into command packets and validates them.
//   A write command becomes a single-cycle regmap write. A read command
//   fetches one register and sends a 2-byte reply (address, data) through
//   the UART transmitter. Protocol errors are counted in a saturating
//   8-bit counter that can be read back for debug.
//
// Packet: byte0 header (0xA in [7:4], [3]=1 write / 0 read), byte1 address,
//         byte2 data (sent but ignored for reads), byte3 checksum if enabled.
//
// Build option:
//   CMD_CHECKSUM_EN - when defined, packets carry a fourth byte that must
//                     equal byte0^byte1^byte2. When undefined, packets are
//                     three bytes long.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   rx_data/rx_valid        received byte and its one-cycle strobe
//   rx_frame_err            stop-bit error, qualified by rx_valid
//   cfg_addr/cfg_wdata      regmap address (reads and writes) and write data
//   cfg_we                  one-cycle regmap write strobe
//   cfg_rdata               regmap read data, combinational from cfg_addr
//   tx_data/tx_start        reply byte and one-cycle launch strobe to the TX
//   tx_busy                 TX is shifting; rises the cycle after tx_start
//   err_count               saturating protocol-error count
//   busy                    parser is not idle
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a header byte
// GET_ADDR | header accepted, waiting for the address byte
// GET_DATA | waiting for the data byte
// GET_CHK  | waiting for the checksum byte (checksum builds only)
// EXEC     | one cycle: issue the write, or capture read data
// TX_ADDR  | sending the address byte of a read reply
// TX_DATA  | sending the data byte of a read reply

module config_cmd_parser #(
  parameter int NUMREGS        = 32,
  parameter int AW             = $clog2(NUMREGS),
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_frame_err,
  output logic [AW-1:0] cfg_addr,
  output logic [7:0]    cfg_wdata,
  output logic          cfg_we,
  input  logic [7:0]    cfg_rdata,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic [7:0]    err_count,
  output logic          busy
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    NUMREGS_W = 9'(NUMREGS);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_ADDR = 3'd1;
  localparam logic [2:0] GET_DATA = 3'd2;
`ifdef CMD_CHECKSUM_EN
  localparam logic [2:0] GET_CHK  = 3'd3;
`endif
  localparam logic [2:0] EXEC     = 3'd4;
  localparam logic [2:0] TX_ADDR  = 3'd5;
  localparam logic [2:0] TX_DATA  = 3'd6;

  // Reply handshake phases inside TX_ADDR / TX_DATA.
  localparam logic [1:0] PH_LAUNCH = 2'd0;  // wait for TX idle, then pulse start
  localparam logic [1:0] PH_RISE   = 2'd1;  // cycle in which tx_busy is rising
  localparam logic [1:0] PH_FALL   = 2'd2;  // wait for tx_busy to drop

  logic [2:0]    state_q, state_d;
  logic          wr_q, wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    rsp_q, rsp_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    ph_q, ph_d;
  logic [7:0]    err_q, err_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]    hdr_q, hdr_d;
`endif

  logic err_inc;
  logic tx_start_c;
  logic in_get;
  logic addr_ok;

  assign addr_ok = ({1'b0, addr_q} < NUMREGS_W);

`ifdef CMD_CHECKSUM_EN
  assign in_get = (state_q == GET_ADDR) || (state_q == GET_DATA) || (state_q == GET_CHK);
`else
  assign in_get = (state_q == GET_ADDR) || (state_q == GET_DATA);
`endif

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_d      = rsp_q;
    tx_data_d  = tx_data_q;
    tmo_d      = tmo_q;
    ph_d       = ph_q;
    err_inc    = 1'b0;
    tx_start_c = 1'b0;
`ifdef CMD_CHECKSUM_EN
    hdr_d      = hdr_q;
`endif

    if (rx_valid && rx_frame_err) begin
      // A corrupted byte kills whatever was in progress, including a reply.
      err_inc = 1'b1;
      state_d = IDLE;
      tmo_d   = '0;
      ph_d    = PH_LAUNCH;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data[7:4] == 4'hA) begin
              wr_d    = rx_data[3];
`ifdef CMD_CHECKSUM_EN
              hdr_d   = rx_data;
`endif
              state_d = GET_ADDR;
            end else begin
              err_inc = 1'b1;
            end
          end
        end

        GET_ADDR: begin
          if (rx_valid) begin
            addr_d  = rx_data;
            state_d = GET_DATA;
          end
        end

        GET_DATA: begin
          if (rx_valid) begin
            data_d  = rx_data;
`ifdef CMD_CHECKSUM_EN
            state_d = GET_CHK;
`else
            state_d = EXEC;
`endif
          end
        end

`ifdef CMD_CHECKSUM_EN
        GET_CHK: begin
          if (rx_valid) begin
            if (rx_data == (hdr_q ^ addr_q ^ data_q)) begin
              state_d = EXEC;
            end else begin
              err_inc = 1'b1;
              state_d = IDLE;
            end
          end
        end
`endif

        EXEC: begin
          if (rx_valid) err_inc = 1'b1;
          state_d = IDLE;
          if (!addr_ok) begin
            err_inc = 1'b1;
          end else if (!wr_q) begin
            rsp_d     = cfg_rdata;
            tx_data_d = addr_q;
            ph_d      = PH_LAUNCH;
            state_d   = TX_ADDR;
          end
        end

        TX_ADDR, TX_DATA: begin
          if (rx_valid) err_inc = 1'b1;
          case (ph_q)
            PH_LAUNCH: begin
              if (!tx_busy) begin
                tx_start_c = 1'b1;
                ph_d       = PH_RISE;
              end
            end
            PH_RISE: ph_d = PH_FALL;
            default: begin
              if (!tx_busy) begin
                ph_d = PH_LAUNCH;
                if (state_q == TX_ADDR) begin
                  tx_data_d = rsp_q;
                  state_d   = TX_DATA;
                end else begin
                  state_d = IDLE;
                end
              end
            end
          endcase
        end

        default: state_d = IDLE;
      endcase

      // Inter-byte timer: an accepted byte restarts it, otherwise it runs
      // while a packet is partially received.
      if (in_get) begin
        if (rx_valid) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          err_inc = 1'b1;
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    end

    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rsp_q     <= '0;
      tx_data_q <= '0;
      tmo_q     <= '0;
      ph_q      <= PH_LAUNCH;
      err_q     <= '0;
`ifdef CMD_CHECKSUM_EN
      hdr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rsp_q     <= rsp_d;
      tx_data_q <= tx_data_d;
      tmo_q     <= tmo_d;
      ph_q      <= ph_d;
      err_q     <= err_d;
`ifdef CMD_CHECKSUM_EN
      hdr_q     <= hdr_d;
`endif
    end
  end

  assign cfg_addr  = addr_q[AW-1:0];
  assign cfg_wdata = data_q;
  // Out-of-range addresses never reach the regmap as a write.
  assign cfg_we    = (state_q == EXEC) && wr_q && addr_ok;
  // Gated directly by tx_busy so a start can never overlap a busy TX.
  assign tx_start  = tx_start_c;
  assign tx_data   = tx_data_q;
  assign err_count = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_config_cmd_parser.sv
module tb_config_cmd_parser;

  localparam int T = 4096;
`ifdef CMD_CHECKSUM_EN
  localparam int PKT_LEN = 4;
`else
  localparam int PKT_LEN = 3;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_frame_err = 1'b0;
  logic [4:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_we;
  logic [7:0] cfg_rdata;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] err_count;
  logic       busy;

  logic rsp_busy = 1'b0;
  logic bp_busy = 1'b0;
  int   tx_hold = 8;
  assign tx_busy = rsp_busy | bp_busy;

  config_cmd_parser dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_we(cfg_we), .cfg_rdata(cfg_rdata),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment regmap: reset contents are index ^ 0x6C (so reg 0x12 = 0x7E).
  logic [7:0] env_regs [0:31];
  assign cfg_rdata = env_regs[cfg_addr];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) env_regs[i] <= 8'(i) ^ 8'h6C;
    end else if (cfg_we) begin
      env_regs[cfg_addr] <= cfg_wdata;
    end
  end

  // ---------------- scoreboard / behavioural model ----------------
  typedef struct { int c; logic [7:0] a; logic [7:0] d; } we_t;
  we_t        exp_we[$];
  logic [7:0] exp_tx[$];
  logic [7:0] pkt[$];
  logic [7:0] mdl_regs [0:31];
  int         mdl_err = 0;
  bit         rsp_pending = 0;
  int         last_rx_cyc = -1000;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  logic [7:0] last_we_addr = 8'h00;
  logic [7:0] last_we_data = 8'h00;
  int tx_starts = 0;
  logic [7:0] tx_log[$];
  logic [7:0] last_tx = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void err_up();
    if (mdl_err < 255) mdl_err++;
  endfunction

  function automatic void model_reset();
    pkt.delete();
    exp_we.delete();
    exp_tx.delete();
    rsp_pending = 0;
    mdl_err = 0;
    for (int i = 0; i < 32; i++) mdl_regs[i] = 8'(i) ^ 8'h6C;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit fe, input int c);
    logic [7:0] h, a, d;
    bit ok;
    last_rx_cyc = c;
    if (fe) begin
      err_up();
      pkt.delete();
      return;
    end
    if (rsp_pending) begin
      err_up();
      return;
    end
    if (pkt.size() == 0) begin
      if (b[7:4] == 4'hA) pkt.push_back(b);
      else err_up();
      return;
    end
    pkt.push_back(b);
    if (pkt.size() == PKT_LEN) begin
      h = pkt[0]; a = pkt[1]; d = pkt[2];
      ok = (PKT_LEN == 3) || (pkt[PKT_LEN-1] == (h ^ a ^ d));
      if (!ok || a >= 8'd32) begin
        err_up();
      end else if (h[3]) begin
        exp_we.push_back('{c: c + 1, a: a, d: d});
        mdl_regs[a[4:0]] = d;
      end else begin
        exp_tx.push_back(a);
        exp_tx.push_back(mdl_regs[a[4:0]]);
        rsp_pending = 1;
      end
      pkt.delete();
    end
  endfunction

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    bit we_now;
    if (reset_n) begin
      while (exp_we.size() > 0 && exp_we[0].c < cyc) void'(exp_we.pop_front());
      we_now = (exp_we.size() > 0) && (exp_we[0].c == cyc);
      chk("cfg_we", 32'(cfg_we), 32'(we_now));
      if (cfg_we) begin
        we_cnt++;
        last_we_addr = 8'(cfg_addr);
        last_we_data = cfg_wdata;
      end
      if (cfg_we && we_now) begin
        chk("cfg_addr", 32'(cfg_addr), 32'(exp_we[0].a));
        chk("cfg_wdata", 32'(cfg_wdata), 32'(exp_we[0].d));
        void'(exp_we.pop_front());
      end
      if (tx_start) begin
        chk("tx_start_vs_busy", 32'(tx_busy), 32'd0);
        tx_starts++;
        tx_log.push_back(tx_data);
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: got tx_data=%0h expected no tx_start", tx_data);
        end else begin
          chk("tx_data", 32'(tx_data), 32'(exp_tx[0]));
          last_tx = exp_tx.pop_front();
        end
      end else if (rsp_busy) begin
        chk("tx_data_hold", 32'(tx_data), 32'(last_tx));
      end
      if (pkt.size() > 0 && (cyc - last_rx_cyc) == T + 2) begin
        err_up();
        pkt.delete();
      end
      if ((cyc - last_rx_cyc) >= 3 && !(pkt.size() > 0 && (cyc - last_rx_cyc) >= T - 2))
        chk("err_count", 32'(err_count), 32'(mdl_err));
    end
  end

  // TX UART stand-in: busy from the cycle after tx_start for tx_hold cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && reset_n) begin
        @(posedge clk); #1 rsp_busy = 1'b1;
        repeat (tx_hold) @(posedge clk);
        #1 rsp_busy = 1'b0;
        if (exp_tx.size() == 0) rsp_pending = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input bit fe = 1'b0);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1; rx_frame_err = fe;
    model_byte(b, fe, cyc);
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_frame_err = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] h, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] c);
    send_byte(h); send_byte(a); send_byte(d);
    if (PKT_LEN == 4) send_byte(c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_done(input int budget);
    int k = 0;
    while ((rsp_pending || tx_busy) && k < budget) begin
      @(posedge clk); k++;
    end
    #1;
    total++;
    if (k >= budget) begin
      bad++;
      $display("FAIL rsp_wait: reply still pending after %0d cycles, expected done", budget);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cfg_addr"}, 32'(cfg_addr), 32'd0);
    chk({tag, "_cfg_wdata"}, 32'(cfg_wdata), 32'd0);
    chk({tag, "_cfg_we"}, 32'(cfg_we), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int s0, w0, k;
    model_reset();
    #2 reset_n = 1'b0;
    idle(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    idle(3);

    // Write 0x3C to register 5.
    send_pkt(8'hA8, 8'h05, 8'h3C, 8'h91);
    idle(5);
    chk("wr_count", 32'(we_cnt), 32'd1);
    chk("wr_addr_lit", 32'(last_we_addr), 32'h05);
    chk("wr_data_lit", 32'(last_we_data), 32'h3C);
    chk("wr_err_lit", 32'(err_count), 32'd0);

    // Read register 0x12 (0x7E).
    tx_hold = 8;
    send_pkt(8'hA0, 8'h12, 8'h00, 8'hB2);
    wait_rsp_done(300);
    idle(4);
    chk("rd_tx_count", 32'(tx_log.size()), 32'd2);
    if (tx_log.size() >= 2) begin
      chk("rd_tx0_lit", 32'(tx_log[0]), 32'h12);
      chk("rd_tx1_lit", 32'(tx_log[1]), 32'h7E);
    end
    chk("rd_no_write", 32'(we_cnt), 32'd1);

    // Error sources.
    send_byte(8'h5F);
    idle(4);
    chk("bad_hdr_err", 32'(err_count), 32'd1);
    send_pkt(8'hA8, 8'h20, 8'h11, 8'h99);
    idle(5);
    chk("oor_err", 32'(err_count), 32'd2);
    chk("oor_no_write", 32'(we_cnt), 32'd1);
    send_byte(8'hA8); send_byte(8'h05); send_byte(8'h3C); send_byte(8'h00);
    idle(5);
    chk("badchk_err", 32'(err_count), 32'd3);
    chk("badchk_writes", 32'(we_cnt), (PKT_LEN == 4) ? 32'd1 : 32'd2);

    // Frame error mid-packet.
    send_byte(8'hA8); send_byte(8'h07); send_byte(8'hA8, 1'b1);
    idle(4);
    chk("frame_err", 32'(err_count), 32'd4);
    chk("frame_idle", 32'(busy), 32'd0);

    // Inter-byte timeout.
    send_byte(8'hA8); send_byte(8'h03);
    idle(4000);
    chk("tmo_still_busy", 32'(busy), 32'd1);
    idle(200);
    chk("tmo_idle", 32'(busy), 32'd0);
    chk("tmo_err", 32'(err_count), 32'd5);

    // Backpressure on a read of reg 5, then a byte dropped during TX_DATA.
    bp_busy = 1'b1;
    s0 = tx_starts;
    w0 = we_cnt;
    send_pkt(8'hA0, 8'h05, 8'h00, 8'hA5);
    idle(100);
    chk("bp_no_start", 32'(tx_starts - s0), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    tx_hold = 30;
    bp_busy = 1'b0;
    k = 0;
    while (tx_starts < s0 + 2 && k < 200) begin @(posedge clk); k++; end
    #1;
    chk("bp_second_start", 32'(tx_starts - s0), 32'd2);
    idle(3);
    send_byte(8'hA8);
    wait_rsp_done(300);
    idle(4);
    chk("overlap_err", 32'(err_count), 32'd6);
    if (tx_log.size() >= 2) begin
      chk("bp_tx0_lit", 32'(tx_log[tx_log.size()-2]), 32'h05);
      chk("bp_tx1_lit", 32'(tx_log[tx_log.size()-1]), 32'h3C);
    end
    chk("bp_no_write", 32'(we_cnt - w0), 32'd0);

    // Reset in the middle of a packet.
    send_byte(8'hA8); send_byte(8'h03);
    @(posedge clk); #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(3);
    w0 = we_cnt;
    send_pkt(8'hA8, 8'h0A, 8'h55, 8'hF7);
    idle(5);
    chk("rst_wr_count", 32'(we_cnt - w0), 32'd1);
    chk("rst_wr_addr", 32'(last_we_addr), 32'h0A);
    chk("rst_wr_data", 32'(last_we_data), 32'h55);
    chk("rst_err", 32'(err_count), 32'd0);

    // Saturation.
    for (int i = 0; i < 300; i++) send_byte(8'h5F);
    idle(5);
    chk("sat_err", 32'(err_count), 32'hFF);

    chk("we_queue_empty", 32'(exp_we.size()), 32'd0);
    chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
